mpc_sram_arbiter: RTL
=====================

Name: mpc_sram_arbiter

Overview:
Round-robin arbiter that shares one single-port 1RW SRAM (one access per cycle, registered read data one cycle after access, read-during-write returns old contents, rdata held while cs low) among NUM_REQ requesters. Each requester has a valid/ready request channel and a valid/ready response channel. The arbiter tracks the one outstanding access and routes its response back to the owner. Response backpressure stalls the SRAM so its held rdata remains valid.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
ADDR_SIZE, 10, SRAM address width
DATA_SIZE, 32, SRAM data width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accepted (combinational)
req_we  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_SIZE  flattened addresses; requester i at bits [i*ADDR_SIZE +: ADDR_SIZE]
req_wdata  in  NUM_REQ*DATA_SIZE  flattened write data, same packing
rsp_valid  out  NUM_REQ  response valid, one-hot or zero
rsp_ready  in  NUM_REQ  response accept
rsp_rdata  out  DATA_SIZE  response data, shared by all requesters
sram_cs  out  1  SRAM chip select
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_SIZE  SRAM address
sram_wdata  out  DATA_SIZE  SRAM write data
sram_rdata  in  DATA_SIZE  SRAM read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Registered state: priority pointer ptr (0..NUM_REQ-1); owner index; rsp_valid.
- Reset values: ptr=0, rsp_valid=0. While rst_n=0, req_ready=0 and sram_cs=0, forced combinationally.
- stall = rsp_valid[owner] & ~rsp_ready[owner].
- Arbitration: when not stalled, grant the first requester with req_valid=1, searching ptr, ptr+1, ... with wrap at NUM_REQ. The grant is at most one-hot.
- Grant outputs: req_ready=grant. sram_cs=|grant. sram_we, sram_addr and sram_wdata are muxed from the granted requester in the same cycle.
- Idle or stalled cycles: sram_cs=0. sram_we, sram_addr and sram_wdata are driven 0.
- Accept: accept = req_valid[i] & req_ready[i]. On accept: owner<=i, ptr<=(i+1) mod NUM_REQ, rsp_valid<=onehot(i) at the next edge.
- Latency: accept in cycle N gives rsp_valid in cycle N+1.
- Response data: rsp_rdata = sram_rdata, passthrough, valid whenever rsp_valid!=0.
  - Read: data at addr.
  - Write: the write acknowledge carries the pre-write contents of addr.
- Response handshake: the response completes when rsp_valid[owner] & rsp_ready[owner].
  - On completion with no new accept the same cycle, rsp_valid<=0.
  - A new accept in the completion cycle is allowed, giving throughput of 1 access/cycle.
- Backpressure: while stalled, no grant, sram_cs=0, and rsp_valid, owner, ptr and rsp_rdata all hold.
- Requester rule: a requester holds req_we, req_addr and req_wdata stable while req_valid=1 and not accepted. The arbiter does not check this.
- ptr changes only on accept. An unaccepted requester keeps priority.
- Reset mid-operation: any pending response is discarded (rsp_valid=0). No SRAM access is issued in reset cycles.
- Implemented with combinational priority rotation, registered state only as above. No SRAM instance inside.

Test Plan:
1. R0 writes addr 5 = 0xDEADBEEF, then reads addr 5 with rsp_ready=1 -> write acknowledge rsp_valid=01 one cycle after accept; read returns rsp_rdata=0xDEADBEEF on rsp_valid=01 at N+1.
2. R0 and R1 both continuously valid, reads of addrs 1 and 2, rsp_ready=11 -> grants alternate R0,R1,R0,R1 starting at R0 after reset; one response per cycle to the correct owner.
3. R1 read, rsp_ready[1]=0 for 3 cycles while R0 valid -> sram_cs=0, req_ready=00, rsp_valid=10 and rsp_rdata stable for 3 cycles; on release R0 is granted in the same cycle.
4. NUM_REQ=3, only R2 valid, then all valid -> R2 granted; ptr wraps to 0; following grants R0,R1,R2.
5. rst_n=0 asserted on the cycle after a read accept -> rsp_valid=000 next cycle, no sram_cs, ptr=0 after release.
6. Write addr 7 = 0x1, then write addr 7 = 0x2 back-to-back -> second write acknowledge rsp_rdata=0x1; a later read of addr 7 returns 0x2.

Source files
------------

// File: rtl/mpc_sram_arbiter.sv
// Round-robin arbiter that shares one single-port SRAM among NUM_REQ requesters.
// Only one access is outstanding at a time; response backpressure freezes the SRAM so its held rdata stays valid.
module mpc_sram_arbiter_lane #(
    parameter int ADDR_SIZE = 10,
    parameter int DATA_SIZE = 32
) (
    input  logic                 gnt,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_SIZE-1:0] wdata,
    output logic                 we_m,
    output logic [ADDR_SIZE-1:0] addr_m,
    output logic [DATA_SIZE-1:0] wdata_m
);
    // Masked by the one-hot grant so the top can OR the lanes together.
    assign we_m    = gnt & we;
    assign addr_m  = addr & {ADDR_SIZE{gnt}};
    assign wdata_m = wdata & {DATA_SIZE{gnt}};
endmodule

module mpc_sram_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int ADDR_SIZE = 10,
    parameter int DATA_SIZE = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [DATA_SIZE-1:0]           rsp_rdata,
    output logic                           sram_cs,
    output logic                           sram_we,
    output logic [ADDR_SIZE-1:0]           sram_addr,
    output logic [DATA_SIZE-1:0]           sram_wdata,
    input  logic [DATA_SIZE-1:0]           sram_rdata
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]                       ptr, owner, gidx, ptr_nxt;
    logic                                stall;
    logic [2*NUM_REQ-1:0]                req_dbl, gnt_dbl;
    logic [NUM_REQ-1:0]                  req_rot, gnt_rot, grant;
    logic [NUM_REQ-1:0]                  lane_we;
    logic [NUM_REQ-1:0][ADDR_SIZE-1:0]   lane_addr;
    logic [NUM_REQ-1:0][DATA_SIZE-1:0]   lane_wdata;

    assign stall = rsp_valid[owner] & ~rsp_ready[owner];

    // Rotate ptr down to bit 0, keep the lowest set bit, rotate back.
    assign req_dbl = {req_valid, req_valid} >> ptr;
    assign req_rot = req_dbl[NUM_REQ-1:0];
    assign gnt_rot = req_rot & (~req_rot + NUM_REQ'(1));
    assign gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    assign grant   = (rst_n && !stall) ? gnt_dbl[2*NUM_REQ-1 -: NUM_REQ] : '0;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) gidx = PW'(i);
    end

    assign ptr_nxt = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        mpc_sram_arbiter_lane #(
            .ADDR_SIZE (ADDR_SIZE),
            .DATA_SIZE (DATA_SIZE)
        ) u_lane (
            .gnt     (grant[g]),
            .we      (req_we[g]),
            .addr    (req_addr[g*ADDR_SIZE +: ADDR_SIZE]),
            .wdata   (req_wdata[g*DATA_SIZE +: DATA_SIZE]),
            .we_m    (lane_we[g]),
            .addr_m  (lane_addr[g]),
            .wdata_m (lane_wdata[g])
        );
    end

    always_comb begin
        sram_addr  = '0;
        sram_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sram_addr  = sram_addr  | lane_addr[i];
            sram_wdata = sram_wdata | lane_wdata[i];
        end
    end

    assign sram_we   = |lane_we;
    assign sram_cs   = |grant;
    assign req_ready = grant;
    assign rsp_rdata = sram_rdata;

    // A new grant may coincide with completion of the previous response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= '0;
            owner     <= '0;
            rsp_valid <= '0;
        end else if (|grant) begin
            owner     <= gidx;
            ptr       <= ptr_nxt;
            rsp_valid <= grant;
        end else if (rsp_valid[owner] && rsp_ready[owner]) begin
            rsp_valid <= '0;
        end
    end
endmodule
